// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Two-master, one-slave AXI read-channel arbiter. Master 0 is the instruction
//   cache, master 1 the data cache. One burst is in flight at a time; the owner
//   keeps the bus until the beat carrying s_rlast completes. Simultaneous
//   requests are resolved round-robin against the last owner.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_mN_ar*                     master N read-address request (N = 0, 1)
//   o_mN_arready                 request accepted (IDLE grant cycle only)
//   o_mN_rdata/rresp             broadcast of slave R data/response
//   o_mN_rvalid/rlast            slave R valid/last, routed to owner only
//   i_mN_rready                  master N ready for a beat
//   o_s_ar*, o_s_arvalid         registered request to slave
//   i_s_arready                  slave accepts address
//   i_s_r*                       slave R channel
//   o_s_rready                   owner's rready during DATA, else 0
//   o_owner                      current / last granted master
//   o_err                        sticky burst-length mismatch flag
module axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_m0_araddr,
   input  logic              i_m0_arvalid,
   input  logic [1:0]        i_m0_arburst,
   input  logic [7:0]        i_m0_arlen,
   input  logic [2:0]        i_m0_arsize,
   output logic              o_m0_arready,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic [1:0]        o_m0_rresp,
   output logic              o_m0_rvalid,
   output logic              o_m0_rlast,
   input  logic              i_m0_rready,
   input  logic [ADDR_W-1:0] i_m1_araddr,
   input  logic              i_m1_arvalid,
   input  logic [1:0]        i_m1_arburst,
   input  logic [7:0]        i_m1_arlen,
   input  logic [2:0]        i_m1_arsize,
   output logic              o_m1_arready,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic [1:0]        o_m1_rresp,
   output logic              o_m1_rvalid,
   output logic              o_m1_rlast,
   input  logic              i_m1_rready,
   output logic [ADDR_W-1:0] o_s_araddr,
   output logic [1:0]        o_s_arburst,
   output logic [7:0]        o_s_arlen,
   output logic [2:0]        o_s_arsize,
   output logic              o_s_arvalid,
   input  logic              i_s_arready,
   input  logic [DATA_W-1:0] i_s_rdata,
   input  logic [1:0]        i_s_rresp,
   input  logic              i_s_rvalid,
   input  logic              i_s_rlast,
   output logic              o_s_rready,
   output logic              o_owner,
   output logic              o_err
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_owner;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_burst;
   logic [7:0]        r_len;
   logic [2:0]        r_size;
   logic [8:0]        r_cnt;

   logic              w_req_any;
   logic              w_gnt_idx;
   logic              w_grant;
   logic              w_beat;
   logic              w_own_rready;
   logic              w_len_bad;

   // On a tie the master that did not own the bus last wins.
   assign w_req_any    = i_m0_arvalid | i_m1_arvalid;
   assign w_gnt_idx    = (i_m0_arvalid & i_m1_arvalid) ? ~r_owner : i_m1_arvalid;
   assign w_own_rready = r_owner ? i_m1_rready : i_m0_rready;

   // Last beat must land exactly on arlen; a non-last beat must not go past it.
   assign w_len_bad = i_s_rlast ? (r_cnt != {1'b0, r_len}) : (r_cnt >= {1'b0, r_len});

   assign o_m0_rdata  = i_s_rdata;
   assign o_m1_rdata  = i_s_rdata;
   assign o_m0_rresp  = i_s_rresp;
   assign o_m1_rresp  = i_s_rresp;
   assign o_s_araddr  = r_addr;
   assign o_s_arburst = r_burst;
   assign o_s_arlen   = r_len;
   assign o_s_arsize  = r_size;
   assign o_owner     = r_owner;
   assign o_err       = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_beat       = 1'b0;
      o_m0_arready = 1'b0;
      o_m1_arready = 1'b0;
      o_s_arvalid  = 1'b0;
      o_s_rready   = 1'b0;
      o_m0_rvalid  = 1'b0;
      o_m0_rlast   = 1'b0;
      o_m1_rvalid  = 1'b0;
      o_m1_rlast   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_req_any) begin
               w_grant      = 1'b1;
               o_m0_arready = ~w_gnt_idx;
               o_m1_arready = w_gnt_idx;
               w_state_nxt  = StAddr;
            end
         end
         StAddr: begin
            o_s_arvalid = 1'b1;
            if (i_s_arready) begin
               w_state_nxt = StData;
            end
         end
         StData: begin
            o_s_rready = w_own_rready;
            if (r_owner) begin
               o_m1_rvalid = i_s_rvalid;
               o_m1_rlast  = i_s_rlast;
            end else begin
               o_m0_rvalid = i_s_rvalid;
               o_m0_rlast  = i_s_rlast;
            end
            w_beat = i_s_rvalid & w_own_rready;
            if (w_beat && i_s_rlast) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= 1'b1;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_burst <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_gnt_idx;
            r_addr  <= w_gnt_idx ? i_m1_araddr  : i_m0_araddr;
            r_burst <= w_gnt_idx ? i_m1_arburst : i_m0_arburst;
            r_len   <= w_gnt_idx ? i_m1_arlen   : i_m0_arlen;
            r_size  <= w_gnt_idx ? i_m1_arsize  : i_m0_arsize;
            r_cnt   <= '0;
         end
         if (w_beat) begin
            r_cnt <= r_cnt + 9'd1;
            if (w_len_bad) begin
               r_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m0_araddr, m1_araddr, s_araddr;
   logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [1:0]  m0_arburst, m1_arburst, s_arburst;
   logic [7:0]  m0_arlen, m1_arlen, s_arlen;
   logic [2:0]  m0_arsize, m1_arsize, s_arsize;
   logic [63:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]  m0_rresp, m1_rresp, s_rresp;
   logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
   logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
   logic        owner, err;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] cap[$];
   int          g_stall, g_nonown, g_lastseen, g_arseen;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .i_m0_arburst(m0_arburst),
      .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .o_m0_arready(m0_arready),
      .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp), .o_m0_rvalid(m0_rvalid),
      .o_m0_rlast(m0_rlast), .i_m0_rready(m0_rready),
      .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .i_m1_arburst(m1_arburst),
      .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .o_m1_arready(m1_arready),
      .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp), .o_m1_rvalid(m1_rvalid),
      .o_m1_rlast(m1_rlast), .i_m1_rready(m1_rready),
      .o_s_araddr(s_araddr), .o_s_arburst(s_arburst), .o_s_arlen(s_arlen),
      .o_s_arsize(s_arsize), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
      .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rvalid(s_rvalid),
      .i_s_rlast(s_rlast), .o_s_rready(s_rready), .o_owner(owner), .o_err(err)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      m0_araddr = '0; m0_arvalid = 0; m0_arburst = '0; m0_arlen = '0; m0_arsize = '0;
      m1_araddr = '0; m1_arvalid = 0; m1_arburst = '0; m1_arlen = '0; m1_arsize = '0;
      m0_rready = 0; m1_rready = 0; s_arready = 0;
      s_rdata = '0; s_rresp = '0; s_rvalid = 0; s_rlast = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clr_obs();
      cap.delete();
      g_stall = 0; g_nonown = 0; g_lastseen = 0; g_arseen = 0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
   endtask

   // Slave R driver: presents beats base+i until n of them handshake; owner rready
   // is dropped while the cycle index is in [st_lo, st_hi).
   task automatic drive_beats(input int own, input int n, input int last_at,
                              input logic [63:0] base, input int st_lo, input int st_hi);
      int i = 0;
      int g = 0;
      while (i < n && g < 100) begin
         @(negedge clk);
         s_rvalid = 1'b1;
         s_rdata  = base + 64'(i);
         s_rlast  = (i == last_at);
         s_rresp  = 2'b00;
         if (g >= st_lo && g < st_hi) begin
            m0_rready = 1'b0; m1_rready = 1'b0;
         end else begin
            m0_rready = 1'b1; m1_rready = 1'b1;
         end
         g++;
         #1;
         if (!s_rready) g_stall++;
         if (m0_arready || m1_arready) g_arseen++;
         if (own == 0) begin
            if (m1_rvalid || m1_rlast) g_nonown++;
            if (m0_rvalid && s_rready) begin
               cap.push_back(m0_rdata);
               if (m0_rlast) g_lastseen++;
            end
         end else begin
            if (m0_rvalid || m0_rlast) g_nonown++;
            if (m1_rvalid && s_rready) begin
               cap.push_back(m1_rdata);
               if (m1_rlast) g_lastseen++;
            end
         end
         if (s_rready) i++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_vec++;
      if (owner !== 1'b1) begin
         n_err++; $display("FAIL rst_owner: got %b want 1", owner);
      end
      n_vec++;
      if (err !== 1'b0) begin
         n_err++; $display("FAIL rst_err: got %b want 0", err);
      end
      n_vec++;
      if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0) begin
         n_err++; $display("FAIL rst_ctrl: got %b want 000000",
                           {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid});
      end
      n_vec++;
      if ({s_araddr, s_arlen} !== 40'h0) begin
         n_err++; $display("FAIL rst_req: got %h want 0", {s_araddr, s_arlen});
      end
   endtask

   task automatic test_single();
      int bad = 0;
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd7;
      m0_arburst = 2'd1; m0_arsize = 3'd3;
      #1;
      n_vec++;
      if ({m0_arready, m1_arready} !== 2'b10) begin
         n_err++; $display("FAIL single_grant: got %b want 10", {m0_arready, m1_arready});
      end
      @(negedge clk);
      m0_arvalid = 0;
      #1;
      n_vec++;
      if ({s_arvalid, s_araddr, s_arlen} !== {1'b1, 32'h8000_0040, 8'd7}) begin
         n_err++; $display("FAIL single_ar: got %b %h %0d want 1 80000040 7",
                           s_arvalid, s_araddr, s_arlen);
      end
      n_vec++;
      if ({s_arburst, s_arsize} !== {2'd1, 3'd3}) begin
         n_err++; $display("FAIL single_ar_attr: got %0d %0d want 1 3", s_arburst, s_arsize);
      end
      drive_beats(0, 8, 7, 64'hA000, 0, 0);
      for (int k = 0; k < cap.size(); k++) if (cap[k] !== 64'hA000 + 64'(k)) bad++;
      n_vec++;
      if (cap.size() !== 8 || bad !== 0) begin
         n_err++; $display("FAIL single_beats: got %0d beats %0d bad want 8 0", cap.size(), bad);
      end
      n_vec++;
      if (g_nonown !== 0 || g_lastseen !== 1) begin
         n_err++; $display("FAIL single_route: got nonown=%0d last=%0d want 0 1",
                           g_nonown, g_lastseen);
      end
      next_cycle();
      s_rvalid = 1;
      #1;
      n_vec++;
      if ({s_arvalid, s_rready, m0_rvalid, err} !== 4'b0) begin
         n_err++; $display("FAIL single_idle: got %b want 0000",
                           {s_arvalid, s_rready, m0_rvalid, err});
      end
      s_rvalid = 0;
   endtask

   task automatic test_arb();
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m1_arvalid = 1;
      m0_araddr = 32'h1000; m1_araddr = 32'h2000; m0_arlen = 8'd1; m1_arlen = 8'd1;
      #1;
      n_vec++;
      if ({m0_arready, m1_arready} !== 2'b10) begin
         n_err++; $display("FAIL arb_g1: got %b want 10", {m0_arready, m1_arready});
      end
      @(negedge clk);
      m0_arvalid = 0;
      #1;
      n_vec++;
      if ({s_araddr, m1_arready} !== {32'h1000, 1'b0}) begin
         n_err++; $display("FAIL arb_a1: got %h %b want 00001000 0", s_araddr, m1_arready);
      end
      drive_beats(0, 2, 1, 64'h100, 0, 0);
      n_vec++;
      if (g_arseen !== 0 || cap.size() !== 2) begin
         n_err++; $display("FAIL arb_b1: got arseen=%0d beats=%0d want 0 2", g_arseen, cap.size());
      end
      next_cycle();
      #1;
      n_vec++;
      if ({m0_arready, m1_arready} !== 2'b01) begin
         n_err++; $display("FAIL arb_g2: got %b want 01", {m0_arready, m1_arready});
      end
      @(negedge clk);
      m1_arvalid = 0; m0_araddr = 32'h1100; m0_arvalid = 1;
      #1;
      n_vec++;
      if ({s_araddr, owner} !== {32'h2000, 1'b1}) begin
         n_err++; $display("FAIL arb_a2: got %h %b want 00002000 1", s_araddr, owner);
      end
      clr_obs();
      drive_beats(1, 2, 1, 64'h200, 0, 0);
      n_vec++;
      if (g_arseen !== 0 || g_nonown !== 0 || cap.size() !== 2 || cap[1] !== 64'h201) begin
         n_err++; $display("FAIL arb_b2: got arseen=%0d nonown=%0d beats=%0d want 0 0 2",
                           g_arseen, g_nonown, cap.size());
      end
      next_cycle();
      m1_araddr = 32'h2100; m1_arvalid = 1;
      #1;
      n_vec++;
      if ({m0_arready, m1_arready} !== 2'b10) begin
         n_err++; $display("FAIL arb_g3: got %b want 10", {m0_arready, m1_arready});
      end
      @(negedge clk);
      m0_arvalid = 0;
      #1;
      n_vec++;
      if (s_araddr !== 32'h1100) begin
         n_err++; $display("FAIL arb_a3: got %h want 00001100", s_araddr);
      end
      drive_beats(0, 2, 1, 64'h300, 0, 0);
      next_cycle();
      #1;
      n_vec++;
      if ({m0_arready, m1_arready} !== 2'b01) begin
         n_err++; $display("FAIL arb_g4: got %b want 01", {m0_arready, m1_arready});
      end
      @(negedge clk);
      m1_arvalid = 0;
      #1;
      n_vec++;
      if (s_araddr !== 32'h2100) begin
         n_err++; $display("FAIL arb_a4: got %h want 00002100", s_araddr);
      end
      drive_beats(1, 2, 1, 64'h400, 0, 0);
   endtask

   task automatic test_ar_stall();
      int bad = 0;
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 0; m0_arvalid = 1; m0_araddr = 32'h3000; m0_arlen = 8'd0;
      #1;
      n_vec++;
      if (m0_arready !== 1'b1) begin
         n_err++; $display("FAIL arst_grant: got %b want 1", m0_arready);
      end
      repeat (5) begin
         @(negedge clk);
         m0_arvalid = 0; m0_araddr = 32'hDEAD; s_rvalid = 1; s_rlast = 1; m0_rready = 1;
         #1;
         if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000 || s_rready !== 1'b0 ||
             m0_rvalid !== 1'b0 || m0_rlast !== 1'b0) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++; $display("FAIL arst_hold: got %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      s_rvalid = 0; s_rlast = 0; s_arready = 1;
      #1;
      n_vec++;
      if (s_arvalid !== 1'b1) begin
         n_err++; $display("FAIL arst_hs: got %b want 1", s_arvalid);
      end
      drive_beats(0, 1, 0, 64'h500, 0, 0);
      next_cycle();
      #1;
      n_vec++;
      if (cap.size() !== 1 || err !== 1'b0) begin
         n_err++; $display("FAIL arst_burst: got beats=%0d err=%b want 1 0", cap.size(), err);
      end
   endtask

   task automatic test_r_stall();
      int bad = 0;
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m0_araddr = 32'h4000; m0_arlen = 8'd7;
      @(negedge clk);
      m0_arvalid = 0;
      drive_beats(0, 8, 7, 64'h600, 3, 6);
      for (int k = 0; k < cap.size(); k++) if (cap[k] !== 64'h600 + 64'(k)) bad++;
      n_vec++;
      if (g_stall !== 3) begin
         n_err++; $display("FAIL rst_stall: got %0d rready-low cycles want 3", g_stall);
      end
      n_vec++;
      if (cap.size() !== 8 || bad !== 0 || g_lastseen !== 1) begin
         n_err++; $display("FAIL rstall_order: got beats=%0d bad=%0d last=%0d want 8 0 1",
                           cap.size(), bad, g_lastseen);
      end
      next_cycle();
      #1;
      n_vec++;
      if (err !== 1'b0) begin
         n_err++; $display("FAIL rstall_err: got %b want 0", err);
      end
   endtask

   task automatic test_len_err();
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m0_araddr = 32'h4400; m0_arlen = 8'd7;
      @(negedge clk);
      m0_arvalid = 0;
      drive_beats(0, 9, 8, 64'h700, 0, 0);
      n_vec++;
      if (cap.size() !== 9 || g_lastseen !== 1) begin
         n_err++; $display("FAIL len_long_beats: got %0d last=%0d want 9 1",
                           cap.size(), g_lastseen);
      end
      next_cycle();
      m1_arvalid = 1; m1_araddr = 32'h5000; m1_arlen = 8'd3;
      #1;
      n_vec++;
      if ({err, m1_arready} !== 2'b11) begin
         n_err++; $display("FAIL len_long: got err=%b m1_arready=%b want 1 1", err, m1_arready);
      end
      @(negedge clk);
      m1_arvalid = 0;
      drive_beats(1, 4, 3, 64'h780, 0, 0);
      next_cycle();
      #1;
      n_vec++;
      if (err !== 1'b1) begin
         n_err++; $display("FAIL len_sticky: got %b want 1", err);
      end
      apply_reset(); clr_obs();
      #1;
      n_vec++;
      if (err !== 1'b0) begin
         n_err++; $display("FAIL len_clr: got %b want 0", err);
      end
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m0_araddr = 32'h4800; m0_arlen = 8'd7;
      @(negedge clk);
      m0_arvalid = 0;
      drive_beats(0, 6, 5, 64'h7C0, 0, 0);
      next_cycle();
      m1_arvalid = 1; m1_araddr = 32'h5100; m1_arlen = 8'd0;
      #1;
      n_vec++;
      if ({err, m1_arready} !== 2'b11) begin
         n_err++; $display("FAIL len_short: got err=%b m1_arready=%b want 1 1", err, m1_arready);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset(); clr_obs();
      @(negedge clk);
      s_arready = 1; m0_arvalid = 1; m0_araddr = 32'h6000; m0_arlen = 8'd1;
      @(negedge clk);
      m0_arvalid = 0;
      drive_beats(0, 2, 99, 64'h800, 0, 0);
      @(negedge clk);
      s_rvalid = 1; s_rlast = 0; s_rdata = 64'h802; rst = 1;
      #1;
      n_vec++;
      if ({err, owner, m0_rvalid} !== 3'b101) begin
         n_err++; $display("FAIL mrst_pre: got err/owner/rvalid=%b want 101",
                           {err, owner, m0_rvalid});
      end
      @(negedge clk);
      rst = 0;
      #1;
      n_vec++;
      if ({err, owner} !== 2'b01) begin
         n_err++; $display("FAIL mrst_state: got err/owner=%b want 01", {err, owner});
      end
      n_vec++;
      if ({s_rready, m0_rvalid, m0_rlast, s_arvalid, m0_arready, m1_arready} !== 6'b0) begin
         n_err++; $display("FAIL mrst_ctrl: got %b want 000000",
                           {s_rready, m0_rvalid, m0_rlast, s_arvalid, m0_arready, m1_arready});
      end
      n_vec++;
      if ({s_araddr, s_arlen} !== 40'h0) begin
         n_err++; $display("FAIL mrst_req: got %h want 0", {s_araddr, s_arlen});
      end
      s_rvalid = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_arb();
      test_ar_stall();
      test_r_stall();
      test_len_err();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
